// File: rtl/uart_pkg.sv
// Shared UART types and defaults, imported by the transmitter and (later) the receiver.
package uart_pkg;

    typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_t;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

    // 19200 baud from the 50 MHz system clock
    localparam int DEFAULT_BAUD_DIV = 2604;

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Character handshake between command/response logic (master) and the UART transmitter (slave).
interface uart_tx_cfg_if #(
    parameter int DATA_BITS = 8,
    parameter int DIV_W     = 12
);
    logic                 trmt;
    logic [DATA_BITS-1:0] tx_data;
    logic [DIV_W-1:0]     baud_div;
    logic                 tx_ready;
    logic                 tx_done;
    logic                 busy;

    modport master (
        output trmt, tx_data, baud_div,
        input  tx_ready, tx_done, busy
    );

    modport slave (
        input  trmt, tx_data, baud_div,
        output tx_ready, tx_done, busy
    );
endinterface

// File: rtl/uart_baud_gen.sv
// Loadable bit-period counter: one-cycle tick every div clocks while running.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
    localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(2);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt;

    // Divisors below 2 would leave no room for a distinct tick cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= DIV_W'(DEFAULT_BAUD_DIV);
            cnt   <= '0;
        end else if (load) begin
            div_q <= (div < MIN_DIV) ? MIN_DIV : div;
            cnt   <= '0;
        end else if (run && !tick) begin
            cnt <= cnt + ONE;
        end else begin
            cnt <= '0;
        end
    end

    assign tick = run && (cnt == div_q - ONE);

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int      DATA_BITS = 8,
    parameter parity_t PARITY    = PAR_NONE,
    parameter int      STOP_BITS = 1,
    parameter int      DIV_W     = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_tx_cfg_if.slave  bus,
    output logic          TX
);
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    tx_state_t            state;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_q;
    logic [3:0]           bit_cnt;
    logic                 ready_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 accept;
    logic                 tick;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (PARITY == PAR_ODD) ? ~^d : ^d;
    endfunction

    assign accept = bus.trmt && ready_q;

    uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .run   (state != IDLE),
        .div   (bus.baud_div),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            par_q   <= 1'b0;
            bit_cnt <= '0;
            TX      <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg   <= bus.tx_data;
                        par_q   <= parity_of(bus.tx_data);
                        TX      <= 1'b0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        TX      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
                            if (PARITY != PAR_NONE) begin
                                TX    <= par_q;
                                state <= uart_pkg::PARITY;
                            end else begin
                                TX    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            TX      <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end
                end
                uart_pkg::PARITY: begin
                    if (tick) begin
                        TX      <= 1'b1;
                        bit_cnt <= '0;
                        state   <= STOP;
                    end
                end
                STOP: begin
                    // The last stop tick hands the line back in one edge
                    if (tick) begin
                        if (bit_cnt == LAST_STOP) begin
                            bit_cnt <= '0;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    TX    <= 1'b1;
                end
            endcase
        end
    end

    assign bus.tx_ready = ready_q;
    assign bus.busy     = busy_q;
    assign bus.tx_done  = done_q;

endmodule
